// File: rtl/lane_judge.sv
// lane_judge: multi-player, multi-lane hit judge.
//   Grades key presses against the pending note in each lane. A note is
//   hittable while its age in frame ticks is 0..WINDOW-1. The block keeps
//   a saturating score, a combo count and a score multiplier per player.
// Ports:
//   Clk, Reset_n    system clock, asynchronous active-low reset
//   clear           synchronous clear of all state, same effect as reset
//   frame_tick      one-cycle strobe per video frame
//   note_in         note arrivals per lane, sampled only on frame_tick
//   keys            level key state, bit p*N_LANES+l
//   score/combo/mult  per-player totals, player p at slice p
//   hit_perfect/hit_good/miss/bad_press  one-cycle strobes per (player, lane)
module lane_judge #(
   parameter int N_LANES   = 4,
   parameter int N_PLAYERS = 2,
   parameter int WINDOW    = 8,
   parameter int PERF_WIN  = 2,
   parameter int BASE_PTS  = 5,
   parameter int SCORE_W   = 16,
   parameter int COMBO_W   = 10,
   parameter int MULT_STEP = 10,
   parameter int MULT_MAX  = 4
) (
   input  logic                           Clk,
   input  logic                           Reset_n,
   input  logic                           clear,
   input  logic                           frame_tick,
   input  logic [N_LANES-1:0]             note_in,
   input  logic [N_PLAYERS*N_LANES-1:0]   keys,
   output logic [N_PLAYERS*SCORE_W-1:0]   score,
   output logic [N_PLAYERS*COMBO_W-1:0]   combo,
   output logic [N_PLAYERS*3-1:0]         mult,
   output logic [N_PLAYERS*N_LANES-1:0]   hit_perfect,
   output logic [N_PLAYERS*N_LANES-1:0]   hit_good,
   output logic [N_PLAYERS*N_LANES-1:0]   miss,
   output logic [N_PLAYERS*N_LANES-1:0]   bad_press
);

   localparam int NK     = N_PLAYERS * N_LANES;
   localparam int AGE_W  = $clog2(WINDOW);
   localparam int ACC_W  = SCORE_W + 16;
   localparam int STEP_W = $clog2(MULT_STEP + N_LANES + 1);
   localparam int HIT_W  = $clog2(N_LANES + 1);

   localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(WINDOW - 1);
   localparam logic [AGE_W:0]   PERF_LIM = (AGE_W + 1)'(PERF_WIN);
   localparam logic [N_PLAYERS*3-1:0] MULT_INIT = {N_PLAYERS{3'd1}};

   logic [NK-1:0]                     key_q, pend_q, pend_d, edge_v;
   logic [NK-1:0][AGE_W-1:0]          age_q, age_d;
   logic [N_PLAYERS-1:0][STEP_W-1:0]  step_q, step_d;
   logic [N_PLAYERS*SCORE_W-1:0]      score_d;
   logic [N_PLAYERS*COMBO_W-1:0]      combo_d;
   logic [N_PLAYERS*3-1:0]            mult_d;
   logic [NK-1:0]                     perf_d, good_d, miss_d, bad_d;

   logic                arrive, pend_v, fault;
   logic [AGE_W-1:0]    age_v;
   logic [ACC_W-1:0]    pts, sum_v;
   logic [HIT_W-1:0]    hits;
   logic [COMBO_W:0]    combo_v;
   logic [STEP_W-1:0]   step_v;
   logic [2:0]          mult_p, mult_v;

   assign edge_v = keys & ~key_q;

   always_comb begin
      pend_d  = pend_q;
      age_d   = age_q;
      step_d  = step_q;
      score_d = score;
      combo_d = combo;
      mult_d  = mult;
      perf_d  = '0;
      good_d  = '0;
      miss_d  = '0;
      bad_d   = '0;
      arrive  = 1'b0;
      pend_v  = 1'b0;
      fault   = 1'b0;
      age_v   = '0;
      pts     = '0;
      sum_v   = '0;
      hits    = '0;
      combo_v = '0;
      step_v  = '0;
      mult_p  = 3'd1;
      mult_v  = 3'd1;
      for (int p = 0; p < N_PLAYERS; p++) begin
         pts    = '0;
         hits   = '0;
         mult_p = mult[p*3 +: 3];
         for (int l = 0; l < N_LANES; l++) begin
            arrive = frame_tick & note_in[l];
            pend_v = pend_q[p*N_LANES+l];
            age_v  = age_q[p*N_LANES+l];
            // A new note always displaces the old one; a same-cycle key
            // edge is then judged against the fresh note at age 0.
            if (arrive) begin
               miss_d[p*N_LANES+l] = pend_v;
               pend_v = 1'b1;
               age_v  = '0;
            end
            if (edge_v[p*N_LANES+l] && pend_v) begin
               if ({1'b0, age_v} < PERF_LIM) begin
                  perf_d[p*N_LANES+l] = 1'b1;
                  pts = pts + ACC_W'(2 * BASE_PTS) * ACC_W'(mult_p);
               end else begin
                  good_d[p*N_LANES+l] = 1'b1;
                  pts = pts + ACC_W'(BASE_PTS) * ACC_W'(mult_p);
               end
               hits   = hits + HIT_W'(1);
               pend_v = 1'b0;
               age_v  = '0;
            end else if (edge_v[p*N_LANES+l]) begin
               bad_d[p*N_LANES+l] = 1'b1;
            end else if (frame_tick && pend_v && !arrive) begin
               if (age_v == AGE_LAST) begin
                  miss_d[p*N_LANES+l] = 1'b1;
                  pend_v = 1'b0;
                  age_v  = '0;
               end else begin
                  age_v = age_v + AGE_W'(1);
               end
            end
            pend_d[p*N_LANES+l] = pend_v;
            age_d[p*N_LANES+l]  = age_v;
         end

         sum_v = ACC_W'(score[p*SCORE_W +: SCORE_W]) + pts;
         if (|sum_v[ACC_W-1:SCORE_W])
            score_d[p*SCORE_W +: SCORE_W] = '1;
         else
            score_d[p*SCORE_W +: SCORE_W] = sum_v[SCORE_W-1:0];

         fault = |(miss_d[p*N_LANES +: N_LANES] | bad_d[p*N_LANES +: N_LANES]);
         if (fault) begin
            combo_d[p*COMBO_W +: COMBO_W] = '0;
            step_d[p] = '0;
            mult_d[p*3 +: 3] = 3'd1;
         end else begin
            combo_v = {1'b0, combo[p*COMBO_W +: COMBO_W]} + (COMBO_W + 1)'(hits);
            combo_d[p*COMBO_W +: COMBO_W] = combo_v[COMBO_W] ? '1 : combo_v[COMBO_W-1:0];
            // At most N_LANES multiplier steps can be crossed in one cycle.
            step_v = step_q[p] + STEP_W'(hits);
            mult_v = mult_p;
            for (int i = 0; i < N_LANES; i++) begin
               if (step_v >= STEP_W'(MULT_STEP)) begin
                  step_v = step_v - STEP_W'(MULT_STEP);
                  if (mult_v < 3'(MULT_MAX))
                     mult_v = mult_v + 3'd1;
               end
            end
            step_d[p] = step_v;
            mult_d[p*3 +: 3] = mult_v;
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         key_q       <= '0;
         pend_q      <= '0;
         age_q       <= '0;
         step_q      <= '0;
         score       <= '0;
         combo       <= '0;
         mult        <= MULT_INIT;
         hit_perfect <= '0;
         hit_good    <= '0;
         miss        <= '0;
         bad_press   <= '0;
      end else if (clear) begin
         key_q       <= '0;
         pend_q      <= '0;
         age_q       <= '0;
         step_q      <= '0;
         score       <= '0;
         combo       <= '0;
         mult        <= MULT_INIT;
         hit_perfect <= '0;
         hit_good    <= '0;
         miss        <= '0;
         bad_press   <= '0;
      end else begin
         key_q       <= keys;
         pend_q      <= pend_d;
         age_q       <= age_d;
         step_q      <= step_d;
         score       <= score_d;
         combo       <= combo_d;
         mult        <= mult_d;
         hit_perfect <= perf_d;
         hit_good    <= good_d;
         miss        <= miss_d;
         bad_press   <= bad_d;
      end
   end

endmodule

// File: tb/tb_lane_judge.sv
// tb_lane_judge: directed scenarios plus randomized play for lane_judge,
// every cycle compared against a frame/note-level reference model.
module tb_lane_judge;

   localparam int NL   = 4;
   localparam int NP   = 2;
   localparam int WIN  = 8;
   localparam int PWIN = 2;
   localparam int BASE = 5;
   localparam int SW   = 16;
   localparam int CW   = 10;
   localparam int MSTP = 10;
   localparam int MMAX = 4;
   localparam int NK   = NP * NL;

   logic              Clk, Reset_n, clear, frame_tick;
   logic [NL-1:0]     note_in;
   logic [NK-1:0]     keys;
   logic [NP*SW-1:0]  score;
   logic [NP*CW-1:0]  combo;
   logic [NP*3-1:0]   mult;
   logic [NK-1:0]     hit_perfect, hit_good, miss, bad_press;

   lane_judge #(
      .N_LANES(NL), .N_PLAYERS(NP), .WINDOW(WIN), .PERF_WIN(PWIN),
      .BASE_PTS(BASE), .SCORE_W(SW), .COMBO_W(CW), .MULT_STEP(MSTP),
      .MULT_MAX(MMAX)
   ) dut (
      .Clk(Clk), .Reset_n(Reset_n), .clear(clear), .frame_tick(frame_tick),
      .note_in(note_in), .keys(keys), .score(score), .combo(combo),
      .mult(mult), .hit_perfect(hit_perfect), .hit_good(hit_good),
      .miss(miss), .bad_press(bad_press)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model: one note slot per (player, lane) with its age in frames,
   // plus the unbroken run of hits since the last fault per player
   int            m_pend [NP][NL];
   int            m_age  [NP][NL];
   int            m_score[NP];
   int            m_run  [NP];
   logic [NK-1:0] m_kq;
   logic [NK-1:0] e_perf, e_good, e_miss, e_bad;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int p = 0; p < NP; p++) begin
         m_score[p] = 0;
         m_run[p]   = 0;
         for (int l = 0; l < NL; l++) begin
            m_pend[p][l] = 0;
            m_age[p][l]  = 0;
         end
      end
      m_kq = '0; e_perf = '0; e_good = '0; e_miss = '0; e_bad = '0;
   endtask

   function automatic int exp_mult(input int p);
      int m;
      m = 1 + m_run[p] / MSTP;
      return (m > MMAX) ? MMAX : m;
   endfunction

   function automatic int exp_combo(input int p);
      return (m_run[p] > (1 << CW) - 1) ? (1 << CW) - 1 : m_run[p];
   endfunction

   task automatic model_eval();
      int pts, nh, mlt, k;
      bit flt, ed, arr;
      if (clear) begin
         model_reset();
         return;
      end
      e_perf = '0; e_good = '0; e_miss = '0; e_bad = '0;
      for (int p = 0; p < NP; p++) begin
         pts = 0; nh = 0; flt = 0;
         mlt = exp_mult(p);
         for (int l = 0; l < NL; l++) begin
            k   = p * NL + l;
            ed  = keys[k] && !m_kq[k];
            arr = frame_tick && note_in[l];
            if (arr) begin
               if (m_pend[p][l] != 0) begin e_miss[k] = 1'b1; flt = 1; end
               m_pend[p][l] = 1;
               m_age[p][l]  = 0;
            end
            if (ed && m_pend[p][l] != 0) begin
               if (m_age[p][l] < PWIN) begin
                  e_perf[k] = 1'b1; pts += 2 * BASE * mlt;
               end else begin
                  e_good[k] = 1'b1; pts += BASE * mlt;
               end
               nh++;
               m_pend[p][l] = 0;
            end else if (ed) begin
               e_bad[k] = 1'b1; flt = 1;
            end else if (frame_tick && m_pend[p][l] != 0 && !arr) begin
               if (m_age[p][l] == WIN - 1) begin
                  e_miss[k] = 1'b1; flt = 1; m_pend[p][l] = 0;
               end else begin
                  m_age[p][l]++;
               end
            end
         end
         m_score[p] = (m_score[p] + pts > (1 << SW) - 1) ? (1 << SW) - 1 : m_score[p] + pts;
         m_run[p]   = flt ? 0 : m_run[p] + nh;
      end
      m_kq = keys;
   endtask

   task automatic check_all(input string tag);
      logic [NP*SW-1:0] es;
      logic [NP*CW-1:0] ec;
      logic [NP*3-1:0]  em;
      for (int p = 0; p < NP; p++) begin
         es[p*SW +: SW] = SW'(m_score[p]);
         ec[p*CW +: CW] = CW'(exp_combo(p));
         em[p*3 +: 3]   = 3'(exp_mult(p));
      end
      chk({tag, ".score"}, 64'(score), 64'(es));
      chk({tag, ".combo"}, 64'(combo), 64'(ec));
      chk({tag, ".mult"},  64'(mult),  64'(em));
      chk({tag, ".perfect"}, 64'(hit_perfect), 64'(e_perf));
      chk({tag, ".good"},    64'(hit_good),    64'(e_good));
      chk({tag, ".miss"},    64'(miss),        64'(e_miss));
      chk({tag, ".bad"},     64'(bad_press),   64'(e_bad));
   endtask

   // inputs are set #1 after a rising edge; one call advances one clock
   task automatic step(input string tag);
      model_eval();
      @(posedge Clk);
      #1;
      check_all(tag);
   endtask

   task automatic note_tick(input logic [NL-1:0] n, input string tag);
      frame_tick = 1'b1; note_in = n;
      step(tag);
      frame_tick = 1'b0; note_in = '0;
   endtask

   task automatic press(input int k, input string tag);
      keys[k] = 1'b1;
      step(tag);
      keys[k] = 1'b0;
      step(tag);
   endtask

   logic [NK-1:0] flip;

   initial begin
      Reset_n = 1'b0; clear = 1'b0; frame_tick = 1'b0; note_in = '0; keys = '0;
      model_reset();
      #7;
      check_all("reset");
      repeat (2) @(posedge Clk);
      #1 Reset_n = 1'b1;

      // first hit, PERFECT at age 0
      note_tick(4'b0001, "t1");
      step("t1"); step("t1");
      keys[0] = 1'b1;
      step("t1");
      chk("t1.perfect0", 64'(hit_perfect[0]), 64'd1);
      chk("t1.score0", 64'(score[SW-1:0]), 64'd10);
      chk("t1.combo0", 64'(combo[CW-1:0]), 64'd1);
      chk("t1.mult0", 64'(mult[2:0]), 64'd1);
      chk("t1.score1", 64'(score[2*SW-1:SW]), 64'd0);
      keys[0] = 1'b0;
      step("t1");

      // ten PERFECT hits reach mult 2, the eleventh scores double
      clear = 1'b1; step("clr"); clear = 1'b0;
      for (int i = 0; i < 10; i++) begin
         note_tick(4'b0001, "t2");
         press(0, "t2");
      end
      chk("t2.score10", 64'(score[SW-1:0]), 64'd100);
      chk("t2.mult10", 64'(mult[2:0]), 64'd2);
      note_tick(4'b0001, "t2");
      press(0, "t2");
      chk("t2.score11", 64'(score[SW-1:0]), 64'd120);
      chk("t2.combo11", 64'(combo[CW-1:0]), 64'd11);

      // expiry after eight ticks
      note_tick(4'b0100, "t3");
      for (int i = 0; i < 7; i++) note_tick(4'b0000, "t3");
      note_tick(4'b0000, "t3");
      chk("t3.miss2", 64'(miss[2]), 64'd1);
      chk("t3.combo0", 64'(combo[CW-1:0]), 64'd0);

      // bad press resets combo, then arrival+edge same cycle is PERFECT
      note_tick(4'b0001, "t4");
      press(0, "t4");
      keys[1] = 1'b1;
      step("t4");
      chk("t4.bad1", 64'(bad_press[1]), 64'd1);
      chk("t4.combo", 64'(combo[CW-1:0]), 64'd0);
      keys[1] = 1'b0;
      step("t4");
      keys[1] = 1'b1; frame_tick = 1'b1; note_in = 4'b0010;
      step("t4");
      chk("t4.perfect1", 64'(hit_perfect[1]), 64'd1);
      keys[1] = 1'b0; frame_tick = 1'b0; note_in = '0;
      step("t4");

      // GOOD at age 2, GOOD on the expiry tick, displacement miss
      note_tick(4'b1000, "t5");
      note_tick(4'b0000, "t5");
      note_tick(4'b0000, "t5");
      keys[3] = 1'b1; step("t5");
      chk("t5.good3", 64'(hit_good[3]), 64'd1);
      keys[3] = 1'b0; step("t5");
      note_tick(4'b0001, "t5");
      for (int i = 0; i < 7; i++) note_tick(4'b0000, "t5");
      keys[0] = 1'b1; frame_tick = 1'b1;
      step("t5");
      chk("t5.good_exp", 64'(hit_good[0]), 64'd1);
      chk("t5.no_miss", 64'(miss[0]), 64'd0);
      keys[0] = 1'b0; frame_tick = 1'b0; step("t5");
      note_tick(4'b0100, "t5");
      note_tick(4'b0100, "t5");
      chk("t5.displace", 64'(miss[2]), 64'd1);
      press(2, "t5");
      chk("t5.perf_new", 64'(score[SW-1:0]) > 0, 64'd1);

      // score and combo saturation
      clear = 1'b1; step("clr"); clear = 1'b0;
      for (int i = 0; i < 500; i++) begin
         note_tick(4'b1111, "sat");
         keys[3:0] = 4'hF; step("sat");
         keys[3:0] = 4'h0; step("sat");
      end
      chk("sat.score", 64'(score[SW-1:0]), 64'hFFFF);
      chk("sat.combo", 64'(combo[CW-1:0]), 64'h3FF);
      chk("sat.mult", 64'(mult[2:0]), 64'd4);

      // clear with a key edge in the same cycle
      note_tick(4'b0001, "clr");
      keys[0] = 1'b1; clear = 1'b1;
      step("clr");
      chk("clr.score", 64'(score), 64'd0);
      chk("clr.strobes", 64'(hit_perfect | hit_good | miss | bad_press), 64'd0);
      clear = 1'b0;
      step("clr");
      keys[0] = 1'b0;
      step("clr");

      // async reset with notes pending: no miss strobe, immediate clear
      note_tick(4'b1111, "arst");
      note_tick(4'b0000, "arst");
      #2 Reset_n = 1'b0;
      #1;
      model_reset();
      check_all("arst");
      #2 Reset_n = 1'b1;
      @(posedge Clk); #1;

      // randomized play
      for (int i = 0; i < 4000; i++) begin
         frame_tick = ($urandom_range(0, 3) == 0);
         note_in    = NL'($urandom);
         flip       = NK'($urandom & $urandom & $urandom);
         keys       = keys ^ flip;
         clear      = ($urandom_range(0, 399) == 0);
         step("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
